dmem_bus_unit: RTL and testbench

- MEM-stage load/store unit of the pipelined core.
- Accepts one memory request from the EX/MEM pipeline register and runs it on the external data bus: DAD, DDT, MREQ, WRITE, SIZE and ACKD_n.
- Holds the pipeline stalled until the bus acknowledges, then returns a sign- or zero-extended load result.
- Flags misaligned accesses and bus timeouts.

---
 rtl/core_pkg.sv | 30 +++
 rtl/load_extend.sv | 25 ++
 rtl/dmem_bus_unit.sv | 129 ++++++++++++
 tb/tb_dmem_bus_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the core's memory stage: access sizes and the load/store FSM states.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package core_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // A request is rejected when its address is not naturally aligned or its size is reserved.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_WORD: bad = (addr_lo != 2'b00);
         SZ_HALF: bad = addr_lo[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-aligned load data returned by the data bus.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extend import core_pkg::*; #(
   parameter int BIT_WIDTH = 32
) (
   input  logic [BIT_WIDTH-1:0] raw,
   input  logic [1:0]           size,
   input  logic                 is_unsigned,
   output logic [BIT_WIDTH-1:0] ext
);

   // Select the live lanes and fill the upper bits with zero or the sign bit.
   always_comb begin
      ext = raw;
      case (size)
         SZ_BYTE: ext = is_unsigned ? {{(BIT_WIDTH-8){1'b0}}, raw[7:0]}
                                    : {{(BIT_WIDTH-8){raw[7]}}, raw[7:0]};
         SZ_HALF: ext = is_unsigned ? {{(BIT_WIDTH-16){1'b0}}, raw[15:0]}
                                    : {{(BIT_WIDTH-16){raw[15]}}, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/dmem_bus_unit.sv
// MEM-stage load/store unit: runs one request on the DAD/DDT/MREQ/WRITE/SIZE/ACKD_n bus.
// Latency: aligned access done 2 cycles after acceptance with same-cycle ack; misaligned done after 1.
// Backpressure: stall held while a request is pending on the bus; a new request may be taken during DONE.
module dmem_bus_unit import core_pkg::*; #(
   parameter int BIT_WIDTH = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [BIT_WIDTH-1:0] req_addr,
   input  logic [BIT_WIDTH-1:0] req_wdata,
   output logic                 stall,
   output logic                 done,
   output logic [BIT_WIDTH-1:0] rdata,
   output logic                 misalign,
   output logic                 bus_err,
   output logic [BIT_WIDTH-1:0] DAD,
   inout  wire  [BIT_WIDTH-1:0] DDT,
   output logic                 MREQ,
   output logic                 WRITE,
   output logic [1:0]           SIZE,
   input  logic                 ACKD_n
);

   mem_state_t           state_q, state_d;
   logic [BIT_WIDTH-1:0] wdata_q;
   logic                 unsigned_q;
   logic [7:0]           cnt_q;
   logic [BIT_WIDTH-1:0] load_ext;
   logic                 req_mis;
   logic                 timeout_hit;

   assign req_mis     = is_misaligned(req_size, req_addr[1:0]);
   // Last permitted wait cycle: the counter is about to reach TIMEOUT without an acknowledge.
   assign timeout_hit = ACKD_n && (cnt_q == 8'(TIMEOUT - 1));
   assign done        = (state_q == DONE);

   // Store data is only put on the bus while a write bus cycle is in progress.
   assign DDT = (state_q == BUS && WRITE) ? wdata_q : {BIT_WIDTH{1'bz}};

   load_extend #(.BIT_WIDTH(BIT_WIDTH)) u_load_extend (
      .raw         (DDT),
      .size        (SIZE),
      .is_unsigned (unsigned_q),
      .ext         (load_ext)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state and stall decode; DONE accepts a new request exactly like IDLE.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            stall = (state_q == IDLE) ? req_valid : 1'b0;
            if (req_valid) state_d = req_mis ? DONE : BUS;
            else           state_d = IDLE;
         end
         BUS: begin
            stall = 1'b1;
            if (!ACKD_n || timeout_hit) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, bus drivers, wait counter and one-cycle result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdata_q    <= '0;
         unsigned_q <= 1'b0;
         cnt_q      <= '0;
         rdata      <= '0;
         misalign   <= 1'b0;
         bus_err    <= 1'b0;
         DAD        <= '0;
         MREQ       <= 1'b0;
         WRITE      <= 1'b0;
         SIZE       <= SZ_WORD;
      end else begin
         // Results are only meaningful in DONE, so they clear unless set on the way in.
         rdata    <= '0;
         misalign <= 1'b0;
         bus_err  <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (req_valid) begin
                  wdata_q    <= req_wdata;
                  unsigned_q <= req_unsigned;
                  cnt_q      <= '0;
                  if (req_mis) begin
                     misalign <= 1'b1;
                  end else begin
                     MREQ  <= 1'b1;
                     WRITE <= req_write;
                     SIZE  <= req_size;
                     DAD   <= req_addr;
                  end
               end
            end
            BUS: begin
               if (!ACKD_n) begin
                  MREQ  <= 1'b0;
                  WRITE <= 1'b0;
                  if (!WRITE) rdata <= load_ext;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
                  if (timeout_hit) begin
                     MREQ    <= 1'b0;
                     WRITE   <= 1'b0;
                     bus_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bus_unit.sv
// Directed bench for dmem_bus_unit with a result scoreboard.
// Latency: checks done timing relative to request acceptance.
// Backpressure: checks stall in request, bus and done cycles.
module tb_dmem_bus_unit;
   import core_pkg::*;

   localparam int BW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_write, req_unsigned;
   logic [1:0]    req_size;
   logic [BW-1:0] req_addr, req_wdata;
   logic          stall, done, misalign, bus_err;
   logic [BW-1:0] rdata, dad;
   logic          mreq, write_o, ackd_n;
   logic [1:0]    size_o;
   wire  [BW-1:0] ddt;
   logic          tb_oe;
   logic [BW-1:0] tb_drv;

   typedef struct packed {
      logic [31:0] rdata;
      logic        mis;
      logic        berr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign ddt = tb_oe ? tb_drv : {BW{1'bz}};

   dmem_bus_unit #(.BIT_WIDTH(BW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .done         (done),
      .rdata        (rdata),
      .misalign     (misalign),
      .bus_err      (bus_err),
      .DAD          (dad),
      .DDT          (ddt),
      .MREQ         (mreq),
      .WRITE        (write_o),
      .SIZE         (size_o),
      .ACKD_n       (ackd_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] r, input logic m, input logic b);
      exp_t e;
      e.rdata = r;
      e.mis   = m;
      e.berr  = b;
      sb.push_back(e);
   endtask

   // Compare the DONE-cycle result against the oldest scoreboard entry.
   task automatic chk_result(input string tag);
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s_sb: observed %0d entries expected at least 1", tag, sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rdata"}, rdata, e.rdata);
         chk({tag, "_misalign"}, 32'(misalign), 32'(e.mis));
         chk({tag, "_bus_err"}, 32'(bus_err), 32'(e.berr));
      end
   endtask

   // One isolated request; ack_wait<0 never acknowledges.
   task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int ack_wait,
                          input logic [31:0] bus_data, input int exp_lat, input int exp_bus,
                          input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_berr);
      int cyc;
      int nbus;
      bit seen;
      push_exp(exp_rdata, exp_mis, exp_berr);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; ackd_n = 1'b1; tb_oe = 1'b0;
      @(negedge clk);
      chk({tag, "_stall_req"}, 32'(stall), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = 32'h0; req_size = SZ_WORD; req_addr = 32'h0;
      cyc = 1; nbus = 0; seen = 1'b0;
      while (!seen && cyc <= 20) begin
         if (mreq) begin
            tb_oe  = !w;
            tb_drv = bus_data;
            ackd_n = !(ack_wait >= 0 && nbus >= ack_wait);
         end
         @(negedge clk);
         if (mreq) begin
            nbus++;
            chk({tag, "_stall_bus"}, 32'(stall), 32'd1);
            chk({tag, "_dad"}, dad, addr);
            chk({tag, "_write"}, 32'(write_o), 32'(w));
            chk({tag, "_size"}, 32'(size_o), 32'(sz));
            if (w) chk({tag, "_ddt_store"}, ddt, wd);
         end
         if (done) begin
            seen = 1'b1;
            chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
            chk({tag, "_bus_cycles"}, 32'(nbus), 32'(exp_bus));
            chk({tag, "_stall_done"}, 32'(stall), 32'd0);
            chk_result(tag);
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      ackd_n = 1'b1; tb_oe = 1'b0;
      checks++;
      assert (seen) else begin
         errors++;
         $error("FAIL %s_no_done: observed no done expected done within 20 cycles", tag);
      end
      @(posedge clk); #1;
      tb_oe = 1'b1; tb_drv = 32'h1234_5600;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_mreq_after"}, 32'(mreq), 32'd0);
      chk({tag, "_ddt_released"}, ddt, 32'h1234_5600);
      tb_oe = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; ackd_n = 1'b1; tb_oe = 1'b1; tb_drv = 32'h1234_5600;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_dad", dad, 32'd0);
      chk("rst_mreq", 32'(mreq), 32'd0);
      chk("rst_write", 32'(write_o), 32'd0);
      chk("rst_size", 32'(size_o), 32'd0);
      chk("rst_ddt_z", ddt, 32'h1234_5600);
      @(posedge clk); #1;
      rst = 1'b1; tb_oe = 1'b0;

      // Stale low acknowledge while idle must not produce anything.
      ackd_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stale_ack_done", 32'(done), 32'd0);
         chk("stale_ack_mreq", 32'(mreq), 32'd0);
      end
      @(posedge clk); #1;
      ackd_n = 1'b1;

      // Loads with extension.
      run_req("lw",     1'b0, SZ_WORD, 1'b0, 32'h0800_0010, 32'h0, 0, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_req("lb",     1'b0, SZ_BYTE, 1'b0, 32'h0800_0003, 32'h0, 0, 32'h0000_0080, 2, 1, 32'hFFFF_FF80, 1'b0, 1'b0);
      run_req("lbu",    1'b0, SZ_BYTE, 1'b1, 32'h0800_0003, 32'h0, 0, 32'h0000_0080, 2, 1, 32'h0000_0080, 1'b0, 1'b0);
      run_req("lh",     1'b0, SZ_HALF, 1'b0, 32'h0800_0002, 32'h0, 0, 32'h0000_8001, 2, 1, 32'hFFFF_8001, 1'b0, 1'b0);
      run_req("lhu",    1'b0, SZ_HALF, 1'b1, 32'h0800_0002, 32'h0, 0, 32'hFFFF_8001, 2, 1, 32'h0000_8001, 1'b0, 1'b0);
      run_req("lw_uns", 1'b0, SZ_WORD, 1'b1, 32'h0800_0014, 32'h0, 0, 32'h8000_0000, 2, 1, 32'h8000_0000, 1'b0, 1'b0);
      run_req("lb_wait",1'b0, SZ_BYTE, 1'b0, 32'h0800_0001, 32'h0, 2, 32'h0000_007F, 4, 3, 32'h0000_007F, 1'b0, 1'b0);

      // Stores.
      run_req("sb",     1'b1, SZ_BYTE, 1'b0, 32'hF000_0000, 32'h0000_0041, 0, 32'h0, 2, 1, 32'h0, 1'b0, 1'b0);
      run_req("sh",     1'b1, SZ_HALF, 1'b0, 32'h0800_0006, 32'h0000_BEEF, 1, 32'h0, 3, 2, 32'h0, 1'b0, 1'b0);

      // Rejected requests: no bus cycle, done one cycle after acceptance.
      run_req("lw_mis", 1'b0, SZ_WORD, 1'b0, 32'h0800_0002, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0);
      run_req("sh_mis", 1'b1, SZ_HALF, 1'b0, 32'h0800_0001, 32'h55, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0);
      run_req("rsvd",   1'b0, SZ_RSVD, 1'b0, 32'h0800_0000, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0);

      // No acknowledge: TIMEOUT bus cycles then bus error with zero data.
      run_req("timeout",1'b0, SZ_WORD, 1'b0, 32'h0800_0030, 32'h0, -1, 32'h5555_AAAA, TO + 1, TO, 32'h0, 1'b0, 1'b1);

      // Back-to-back: store, then a load presented during the store's DONE cycle.
      push_exp(32'h0, 1'b0, 1'b0);
      push_exp(32'hCAFE_F00D, 1'b0, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
      req_addr = 32'h0800_0020; req_wdata = 32'h1122_3344;
      @(posedge clk); #1;
      req_valid = 1'b0; ackd_n = 1'b0;
      @(negedge clk);
      chk("b2b_sw_mreq", 32'(mreq), 32'd1);
      chk("b2b_sw_ddt", ddt, 32'h1122_3344);
      @(posedge clk); #1;
      ackd_n = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0800_0024; req_wdata = 32'h0;
      @(negedge clk);
      chk("b2b_sw_done", 32'(done), 32'd1);
      chk_result("b2b_sw");
      @(posedge clk); #1;
      req_valid = 1'b0; ackd_n = 1'b0; tb_oe = 1'b1; tb_drv = 32'hCAFE_F00D;
      @(negedge clk);
      chk("b2b_lw_mreq", 32'(mreq), 32'd1);
      chk("b2b_lw_dad", dad, 32'h0800_0024);
      chk("b2b_lw_write", 32'(write_o), 32'd0);
      chk("b2b_lw_nodone", 32'(done), 32'd0);
      @(posedge clk); #1;
      ackd_n = 1'b1; tb_oe = 1'b0;
      @(negedge clk);
      chk("b2b_lw_done", 32'(done), 32'd1);
      chk_result("b2b_lw");

      // Reset in the middle of a bus cycle: MREQ drops at once, no done follows.
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_addr = 32'h0800_0040;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_mreq_before", 32'(mreq), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_mreq_drop", 32'(mreq), 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      ackd_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("rst_mid_no_done", 32'(done), 32'd0);
         chk("rst_mid_no_mreq", 32'(mreq), 32'd0);
      end
      ackd_n = 1'b1;

      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
